// File: rtl/fifo_rd_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// fifo_rd_stream : drains a registered-output FIFO into a valid/ready stream
// Revision 1.0
// ============================================================================
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [1:0]            level,
  output logic [CNT_WIDTH-1:0]  xfer_cnt
);

  logic                  inflight;
  logic [DATA_WIDTH-1:0] buf1;
  logic                  pop;
  logic                  push;
  logic [2:0]            occupancy;
  logic [1:0]            level_next;
  logic [DATA_WIDTH-1:0] buf0_next;
  logic [DATA_WIDTH-1:0] buf1_next;

  // Reads already in flight reserve a buffer slot, so level + inflight stays <= 2.
  always_comb begin
    pop        = m_valid & m_ready;
    push       = inflight;
    occupancy  = {1'b0, level} + {2'b00, inflight};
    fifo_rd_en = !rst && !fifo_empty && ((occupancy < 3'd2) || pop);

    level_next = level;
    buf0_next  = m_data;
    buf1_next  = buf1;
    case ({pop, push})
      2'b11: begin
        if (level == 2'd2) begin
          buf0_next = buf1;
          buf1_next = fifo_dout;
        end else begin
          buf0_next = fifo_dout;
        end
      end
      2'b10: begin
        if (level == 2'd2) buf0_next = buf1;
        level_next = level - 2'd1;
      end
      2'b01: begin
        if (level == 2'd0) buf0_next = fifo_dout;
        else               buf1_next = fifo_dout;
        level_next = level + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level    <= 2'd0;
      inflight <= 1'b0;
      m_data   <= '0;
      buf1     <= '0;
      m_valid  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      level    <= level_next;
      inflight <= fifo_rd_en;
      m_data   <= buf0_next;
      buf1     <= buf1_next;
      m_valid  <= (level_next != 2'd0);
      xfer_cnt <= xfer_cnt + {{(CNT_WIDTH-1){1'b0}}, pop};
    end
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side master for the synchronous FIFO. It drains the FIFO through its rd_en/fifo_empty/dout interface, where dout is registered and valid one cycle after an accepted read. It presents the words in order as a valid/ready stream to downstream consumers such as a UART TX or a debug port. A 2-entry output buffer absorbs the FIFO read latency, sustains 1 word/cycle under continuous ready, and never loses or duplicates a word under backpressure.

Parameters:
DATA_WIDTH, 16, width of FIFO words and stream data
CNT_WIDTH, 16, width of the delivered-word counter

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous active-high reset
fifo_empty  input  1  FIFO empty flag
fifo_dout  input  DATA_WIDTH  FIFO read data, valid the cycle after an accepted rd_en
fifo_rd_en  output  1  FIFO read request (combinational)
m_valid  output  DATA_WIDTH? no: 1  stream word valid (registered)
m_data  output  DATA_WIDTH  stream word (registered)
m_ready  input  1  downstream accepts word
level  output  2  buffered words, 0..2 (registered)
xfer_cnt  output  CNT_WIDTH  count of completed stream transfers, wraps at 2^CNT_WIDTH

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- State:
  - level (0..2)
  - inflight (1 bit: a read was accepted last cycle)
  - buf0 (head, drives m_data)
  - buf1 (second entry)
  - xfer_cnt
- Reset (rst=1 at posedge):
  - level=0, inflight=0, buf0=buf1=0, xfer_cnt=0.
  - Outputs: m_valid=0, m_data=0, level=0.
  - fifo_rd_en is forced 0 while rst=1.
  - A read in flight at reset is discarded; the FIFO shares rst, so nothing is lost at system level.
- Definitions: pop = m_valid & m_ready; push = inflight. m_valid = (level != 0).
- Read issue: fifo_rd_en = !rst & !fifo_empty & ((level + inflight < 2) | pop).
  - level + inflight never exceeds 2.
  - The path from m_ready to fifo_rd_en is combinational; this is intentional, for full throughput.
- inflight_next = fifo_rd_en. On a push cycle, fifo_dout is sampled at the posedge.
- Buffer update, in priority order:
  - pop & push: level 1 → buf0=fifo_dout; level 2 → buf0=buf1, buf1=fifo_dout. Level unchanged.
  - pop only: level 2 → buf0=buf1. Level decrements.
  - push only: level 0 → buf0=fifo_dout; level 1 → buf1=fifo_dout. Level increments.
  - neither: hold.
- Stream rules:
  - m_data is held stable while m_valid & !m_ready.
  - m_valid never drops without a pop.
  - Words leave in FIFO order.
- Latency: FIFO non-empty with level=0 and inflight=0 in cycle N → fifo_rd_en=1 in N → data captured at the end of N+1 → m_valid=1 in N+2.
- Throughput: with m_ready held at 1, steady state is level=1, inflight=1, one pop and one read per cycle.
- fifo_rd_en is never asserted while fifo_empty=1.
- xfer_cnt increments on every pop and wraps from all-ones to 0.
- Backpressure: with m_ready=0, at most 2 words are pulled from the FIFO. Remaining words stay in the FIFO, which may fill; fifo_full is the writer's concern.
- Simultaneous FIFO becoming empty and pop: no new read, buffer drains normally.

Test Plan:
1. Reset: hold rst 3 cycles with the FIFO holding data → m_valid=0, m_data=0, level=0, xfer_cnt=0, fifo_rd_en=0 throughout.
2. Single word: write 0xA5A5, m_ready=1 → fifo_rd_en pulses 1 cycle at N; m_valid=1 with m_data=0xA5A5 at N+2 for exactly 1 cycle; xfer_cnt=1.
3. Streaming: write 0..31 back-to-back, m_ready=1 → fifo_rd_en high 32 consecutive cycles; m_valid high 32 consecutive cycles starting 2 cycles after the first read; data 0..31 in order; xfer_cnt=32.
4. Backpressure: FIFO holds 0x10..0x13, m_ready=0 → exactly 2 reads, level=2, m_data=0x10 held, fifo_rd_en=0; raise m_ready → 0x10,0x11,0x12,0x13 delivered in order, no gaps after 0x11, no duplicates.
5. Random: 200 words, m_ready random at 50% → scoreboard order exact; level ≤ 2 always; no fifo_rd_en while fifo_empty=1; xfer_cnt=200.
6. Reset mid-operation: assert rst with level=2 and inflight=1 → next cycle m_valid=0, level=0, xfer_cnt=0; after release, new writes 0x55,0x66 are delivered correctly.
